uart_frame_tx: RTL and testbench

Serial transmitter that accepts a 320-bit payload from a frame initiator over a send/send_done handshake. It emits the payload on a UART line as 40 consecutive 8N1 bytes and signals completion with a one-cycle send_done pulse. It sits between the packet/test initiators and the board TX pin, and is the responding end of the send/data/send_done interface.

---
 rtl/uart_frame_tx.sv | 80 ++++++++
 tb/tb_uart_frame_tx.sv | 121 ++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: sends an NBYTES payload as back-to-back 8N1 bytes, LSB byte first, on a rising edge of send
module uart_frame_tx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 115200,
  parameter int NBYTES = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send,
  input  logic [NBYTES*8-1:0]   data,
  output logic                  send_done,
  output logic                  busy,
  output logic                  tx
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [BW-1:0] byte_idx;
  logic send_q;
  logic [NBYTES*8-1:0] sh;
  logic tick, last;
  always_comb begin
    tick = cnt == CW'(DIV - 1);
    last = byte_idx == BW'(NBYTES - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      send_done <= 1'b0;
      busy <= 1'b0;
      cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      send_q <= 1'b0;
    end else begin
      send_q <= send;
      send_done <= 1'b0;
      cnt <= (state == IDLE || state == DONE || tick) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          tx <= ~(send & ~send_q);
          busy <= send & ~send_q;
          if (send & ~send_q) begin
            sh <= data;
            byte_idx <= '0;
            state <= START;
          end
        end
        START: if (tick) begin
          bit_idx <= '0;
          tx <= sh[0];
          state <= DATA;
        end
        DATA: if (tick) begin
          sh <= sh >> 1;
          bit_idx <= bit_idx + 1'b1;
          tx <= bit_idx == 3'd7 ? 1'b1 : sh[1];
          state <= bit_idx == 3'd7 ? STOP : DATA;
        end
        STOP: if (tick) begin
          tx <= last;
          send_done <= last;
          byte_idx <= last ? byte_idx : byte_idx + 1'b1;
          state <= last ? DONE : START;
        end
        DONE: begin
          busy <= 1'b0;
          tx <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: directed self-checking bench for uart_frame_tx at DIV=10, NBYTES=40
module tb_uart_frame_tx;
  logic clk = 1'b0, rst = 1'b1, send = 1'b0;
  logic [319:0] data = '0;
  logic send_done, busy, tx;
  int checks = 0, failures = 0;
  logic [0:9] line0, line1;
  uart_frame_tx #(.CLK_HZ(1000), .BAUD(100), .NBYTES(40)) dut (
    .clk(clk), .rst(rst), .send(send), .data(data),
    .send_done(send_done), .busy(busy), .tx(tx)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic exp_bit(input logic [319:0] d, input int c);
    int k = c / 100;
    int b = (c % 100) / 10;
    return b == 0 ? 1'b0 : b == 9 ? 1'b1 : d[8*k+b-1];
  endfunction
  task automatic frame(input string tag, input logic [319:0] d, input int mode);
    logic [99:0] ob, eb;
    int sd_cnt = 0, busy_bad = 0;
    for (int c = 0; c < 4000; c++) begin
      ob[c%100] = tx;
      eb[c%100] = exp_bit(d, c);
      if (c >= 5 && c < 100 && c % 10 == 5) line0[c/10] = tx;
      if (c >= 105 && c < 200 && c % 10 == 5) line1[(c-100)/10] = tx;
      if (c == 5) line0[0] = tx;
      if (c == 105) line1[0] = tx;
      sd_cnt += int'(send_done);
      busy_bad += int'(busy !== 1'b1);
      if (c % 100 == 99) chk($sformatf("%s_byte%0d", tag, c / 100), 128'(ob), 128'(eb));
      if (mode == 1 && c == 500) send = 1'b0;
      if (mode == 1 && c == 501) send = 1'b1;
      if (mode == 2 && c == 700) data = ~data;
      @(negedge clk);
    end
    chk({tag, "_early_done"}, 128'(sd_cnt), 128'd0);
    chk({tag, "_busy_in_frame"}, 128'(busy_bad), 128'd0);
    chk({tag, "_done_at_4000"}, 128'({send_done, busy, tx}), 128'(3'b111));
    @(negedge clk);
    chk({tag, "_after_done"}, 128'({send_done, busy, tx}), 128'(3'b001));
  endtask
  initial begin
    int n, bad;
    send = 1'b1;
    data = 320'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", 128'({tx, busy, send_done}), 128'(3'b100));
    end
    rst = 1'b0;
    @(negedge clk);
    frame("single_bit", 320'b1, 0);
    chk("single_bit_line0", 128'(line0), 128'(10'b0100000001));
    chk("single_bit_line1", 128'(line1), 128'(10'b0000000001));
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bad += int'({tx, busy, send_done} !== 3'b100);
    end
    chk("held_send_no_restart", 128'(bad), 128'd0);
    send = 1'b0;
    data = {304'h0, 8'h3C, 8'hA5};
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    frame("order", {304'h0, 8'h3C, 8'hA5}, 0);
    chk("order_byte0_line", 128'(line0), 128'(10'b0101001011));
    chk("order_byte1_line", 128'(line1), 128'(10'b0001111001));
    send = 1'b0;
    data = {20{16'hF00D}};
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    frame("send_pulse_mid", {20{16'hF00D}}, 1);
    send = 1'b0;
    data = {10{32'h1234_5678}};
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    frame("data_change_mid", {10{32'h1234_5678}}, 2);
    send = 1'b0;
    @(negedge clk);
    send = 1'b1;
    for (int i = 0; i < 1234; i++) @(negedge clk);
    rst = 1'b1;
    send = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs", 128'({tx, busy, send_done}), 128'(3'b100));
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4100; i++) begin
      @(negedge clk);
      bad += int'({tx, busy, send_done} !== 3'b100);
    end
    chk("mid_reset_stays_idle", 128'(bad), 128'd0);
    data = {40{8'h96}};
    send = 1'b1;
    @(negedge clk);
    frame("after_reset", {40{8'h96}}, 0);
    send = 1'b0;
    @(negedge clk);
    send = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n++;
      if (tx === 1'b0) break;
    end
    chk("b2b_start_latency", 128'(n <= 2 && tx === 1'b0), 128'd1);
    frame("b2b_second", {40{8'h96}}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
